// File: rtl/preadd_macc_frame_if.sv
// preadd_macc_frame_if: sample, control and result bundle of the pre-add MACC frame engine.
interface preadd_macc_frame_if #(
  parameter int WIDTH_PREADD = 25,
  parameter int WIDTH_MULTIPLIER = 18,
  parameter int WIDTH_PRODUCT = 48
);
  logic ce;
  logic in_valid;
  logic in_first;
  logic preadd_sub;
  logic signed [WIDTH_PREADD-1:0] preadd1;
  logic signed [WIDTH_PREADD-1:0] preadd2;
  logic signed [WIDTH_MULTIPLIER-1:0] multiplier;
  logic signed [WIDTH_PRODUCT-1:0] load_data;
  logic signed [WIDTH_PRODUCT-1:0] product;
  logic out_valid;
  logic out_ovf;
  modport master (
    output ce, in_valid, in_first, preadd_sub, preadd1, preadd2, multiplier, load_data,
    input  product, out_valid, out_ovf
  );
  modport slave (
    input  ce, in_valid, in_first, preadd_sub, preadd1, preadd2, multiplier, load_data,
    output product, out_valid, out_ovf
  );
endinterface

// File: rtl/preadd_macc_frame.sv
// preadd_macc_frame: (p1 +/- p2) * m accumulated over NUM_TAPS-sample frames seeded by a bias,
// emitting one result pulse per frame with a sticky signed-overflow flag.
module preadd_macc_frame #(
  parameter int WIDTH_PREADD = 25,
  parameter int WIDTH_MULTIPLIER = 18,
  parameter int WIDTH_PRODUCT = 48,
  parameter int NUM_TAPS = 16
) (
  input logic clk,
  input logic rst_n,
  preadd_macc_frame_if.slave bus
);
  localparam int TW = NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1;
  localparam int PW = WIDTH_PREADD + 1;
  localparam int MW = PW + WIDTH_MULTIPLIER;
  localparam int MSB = WIDTH_PRODUCT - 1;
  localparam logic [TW-1:0] LAST_TAP = TW'(NUM_TAPS - 1);

  logic [TW-1:0] tap, tap_idx;
  logic accept, first, last;
  logic signed [PW-1:0] pre;
  logic s1_v, s1_first, s1_last;
  logic signed [PW-1:0] s1_pre;
  logic signed [WIDTH_MULTIPLIER-1:0] s1_mul;
  logic signed [WIDTH_PRODUCT-1:0] s1_load;
  logic signed [MW-1:0] mul_full;
  logic s2_v, s2_first, s2_last;
  logic signed [WIDTH_PRODUCT-1:0] s2_prod, s2_load;
  logic signed [WIDTH_PRODUCT-1:0] acc, addend, sum, product;
  logic acc_ovf, add_ovf, frame_ovf, out_valid, out_ovf;

  // in_first forces tap 0, so a pending last tap is overridden by the new frame
  always_comb begin
    accept = bus.ce & bus.in_valid;
    tap_idx = bus.in_first ? '0 : tap;
    first = tap_idx == '0;
    last = tap_idx == LAST_TAP;
    pre = bus.preadd_sub ? PW'(bus.preadd1) - PW'(bus.preadd2) : PW'(bus.preadd1) + PW'(bus.preadd2);
    mul_full = MW'(s1_pre) * MW'(s1_mul);
    addend = s2_first ? s2_load : acc;
    sum = addend + s2_prod;
    add_ovf = (addend[MSB] == s2_prod[MSB]) && (sum[MSB] != addend[MSB]);
    frame_ovf = (s2_first ? 1'b0 : acc_ovf) | add_ovf;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tap <= '0;
      s1_v <= 1'b0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
      s1_pre <= '0;
      s1_mul <= '0;
      s1_load <= '0;
      s2_v <= 1'b0;
      s2_first <= 1'b0;
      s2_last <= 1'b0;
      s2_prod <= '0;
      s2_load <= '0;
      acc <= '0;
      acc_ovf <= 1'b0;
      product <= '0;
      out_valid <= 1'b0;
      out_ovf <= 1'b0;
    end else if (bus.ce) begin
      tap <= accept ? (last ? '0 : tap_idx + TW'(1)) : tap;
      s1_v <= accept;
      s1_first <= first;
      s1_last <= last;
      s1_pre <= pre;
      s1_mul <= bus.multiplier;
      s1_load <= bus.load_data;
      s2_v <= s1_v;
      s2_first <= s1_first;
      s2_last <= s1_last;
      s2_prod <= WIDTH_PRODUCT'(mul_full);
      s2_load <= s1_load;
      acc <= s2_v ? sum : acc;
      acc_ovf <= s2_v ? frame_ovf : acc_ovf;
      product <= (s2_v & s2_last) ? sum : product;
      out_ovf <= (s2_v & s2_last) ? frame_ovf : out_ovf;
      out_valid <= s2_v & s2_last;
    end

  assign bus.product = product;
  assign bus.out_valid = out_valid;
  assign bus.out_ovf = out_ovf;
endmodule

// File: tb/tb_preadd_macc_frame.sv
// tb_preadd_macc_frame: scoreboard bench for a 4-tap and a 1-tap instance of preadd_macc_frame.
module tb_preadd_macc_frame;
  localparam int WP = 25;
  localparam int WM = 18;
  localparam int WR = 48;
  localparam longint MAX48 = (64'sd1 <<< 47) - 1;
  localparam longint MIN48 = -(64'sd1 <<< 47);
  localparam longint P42 = 64'sd1 <<< 42;

  typedef struct { longint prod; bit ovf; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q4[$];
  exp_t q1[$];

  preadd_macc_frame_if #(.WIDTH_PREADD(WP), .WIDTH_MULTIPLIER(WM), .WIDTH_PRODUCT(WR)) b4 ();
  preadd_macc_frame_if #(.WIDTH_PREADD(WP), .WIDTH_MULTIPLIER(WM), .WIDTH_PRODUCT(WR)) b1 ();

  preadd_macc_frame #(.WIDTH_PREADD(WP), .WIDTH_MULTIPLIER(WM), .WIDTH_PRODUCT(WR), .NUM_TAPS(4))
    u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  preadd_macc_frame #(.WIDTH_PREADD(WP), .WIDTH_MULTIPLIER(WM), .WIDTH_PRODUCT(WR), .NUM_TAPS(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  // consumers take a result only on an enabled edge
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && b4.ce && b4.out_valid) begin
      if (q4.size() == 0) check("u4_unexpected_valid", 64'(b4.out_valid), 0);
      else begin
        e = q4.pop_front();
        check("u4_product", b4.product, e.prod);
        check("u4_ovf", 64'(b4.out_ovf), 64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && b1.ce && b1.out_valid) begin
      if (q1.size() == 0) check("u1_unexpected_valid", 64'(b1.out_valid), 0);
      else begin
        e = q1.pop_front();
        check("u1_product", b1.product, e.prod);
        check("u1_ovf", 64'(b1.out_ovf), 64'(e.ovf));
      end
    end
  end

  task automatic push(input int d, input longint p, input bit o);
    exp_t e;
    e.prod = p;
    e.ovf = o;
    if (d == 4) q4.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drive(input int d, input bit ce, input bit v, input bit f, input bit s,
                       input longint p1, input longint p2, input longint m, input longint ld);
    if (d == 4) begin
      b4.ce = ce; b4.in_valid = v; b4.in_first = f; b4.preadd_sub = s;
      b4.preadd1 = WP'(p1); b4.preadd2 = WP'(p2); b4.multiplier = WM'(m); b4.load_data = WR'(ld);
    end else begin
      b1.ce = ce; b1.in_valid = v; b1.in_first = f; b1.preadd_sub = s;
      b1.preadd1 = WP'(p1); b1.preadd2 = WP'(p2); b1.multiplier = WM'(m); b1.load_data = WR'(ld);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    b4.ce = 1'b1; b4.in_valid = 1'b0; b4.in_first = 1'b0;
    b1.ce = 1'b1; b1.in_valid = 1'b0; b1.in_first = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(0);
    while ((q4.size() != 0 || q1.size() != 0) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_u4", q4.size(), 0);
    check("drain_u1", q1.size(), 0);
    q4.delete();
    q1.delete();
    idle(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(0);
    b4.preadd_sub = 0; b4.preadd1 = '0; b4.preadd2 = '0; b4.multiplier = '0; b4.load_data = '0;
    b1.preadd_sub = 0; b1.preadd1 = '0; b1.preadd2 = '0; b1.multiplier = '0; b1.load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_u4_product", b4.product, 0);
    check("rst_u4_valid", 64'(b4.out_valid), 0);
    check("rst_u4_ovf", 64'(b4.out_ovf), 0);
    check("rst_u1_product", b1.product, 0);
    check("rst_u1_valid", 64'(b1.out_valid), 0);
    check("rst_u1_ovf", 64'(b1.out_ovf), 0);
    rst_n = 1'b1;
    idle(2);

    // (3+2)*5 four times on bias 100; bias presented on every tap but only tap 0 may use it
    push(4, 200, 0);
    repeat (4) drive(4, 1, 1, 0, 0, 3, 2, 5, 100);
    drain();

    // (3-2)*-7 four times with random gaps and CE stalls carrying bogus data
    push(4, -28, 0);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0, n = $urandom_range(0, 3); g < n; g++)
        if ($urandom_range(0, 1) == 1) drive(4, 0, 1, 0, 1, 9, 1, -7, 77);
        else drive(4, 1, 0, 0, 1, 9, 9, 9, 9);
      drive(4, 1, 1, 0, 1, 3, 2, -7, 0);
    end
    repeat (3) drive(4, 0, 0, 0, 1, 3, 2, -7, 0);
    drain();

    // back-to-back frames, then sticky overflow, then overflow cleared
    push(4, 11, 0);
    push(4, 7, 0);
    push(4, MIN48, 1);
    push(4, 4, 0);
    repeat (4) drive(4, 1, 1, 0, 0, 1, 0, 1, 7);
    repeat (4) drive(4, 1, 1, 0, 1, 2, 1, 3, -5);
    drive(4, 1, 1, 0, 0, 1, 0, 1, MAX48);
    repeat (3) drive(4, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) drive(4, 1, 1, 0, 0, 1, 0, 1, 0);
    drain();

    // realign after 2 and after 3 taps (last tap pending)
    for (int n = 2; n <= 3; n++) begin
      push(4, 4, 0);
      repeat (n) drive(4, 1, 1, 0, 0, 1, 0, 1, 50);
      drive(4, 1, 1, 1, 0, 1, 0, 1, 0);
      repeat (3) drive(4, 1, 1, 0, 0, 1, 0, 1, 0);
      drain();
    end

    // single-tap instance: extremes, overflow, recovery, explicit first
    push(1, P42, 0);
    push(1, MIN48, 1);
    push(1, 6, 0);
    push(1, 16, 0);
    drive(1, 1, 1, 0, 0, -(1 <<< 24), -(1 <<< 24), -(1 <<< 17), 0);
    drive(1, 1, 1, 0, 0, 1, 0, 1, MAX48);
    drive(1, 1, 1, 0, 0, 1, 0, 1, 5);
    drive(1, 1, 1, 1, 1, 4, 1, 2, 10);
    drain();

    // reset mid-frame with two taps in flight
    repeat (2) drive(4, 1, 1, 0, 0, 5, 5, 1, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_u4_product", b4.product, 0);
    check("rst_mid_u4_valid", 64'(b4.out_valid), 0);
    check("rst_mid_u1_product", b1.product, 0);
    b4.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(4, 40, 0);
    repeat (4) drive(4, 1, 1, 0, 0, 5, 5, 1, 0);
    drain();
    check("hold_u4_product", b4.product, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/preadd_macc_frame.md
# preadd_macc_frame

Parametrised pre-add multiply-accumulate engine for the FIR datapath. Each accepted sample computes (PREADD1 ± PREADD2) × MULTIPLIER and accumulates it over a frame of NUM_TAPS samples, seeded by a per-frame bias. At frame end it emits one full-width result with a single-cycle valid and an overflow flag. It is the generic, frame-aware successor to the fixed-width pre-add MACC primitive. It serves symmetric and antisymmetric tap folding without per-tap LOAD sequencing by the controller.

## Interface
- WIDTH_PREADD, 25, width of PREADD1/PREADD2, signed two's complement.
- WIDTH_MULTIPLIER, 18, width of MULTIPLIER, signed.
- WIDTH_PRODUCT, 48, accumulator/output width. Constraint: ≥ WIDTH_PREADD+1+WIDTH_MULTIPLIER.
- NUM_TAPS, 16, samples per frame, ≥1.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CE  in  1  clock enable. All registers hold when low.
- IN_VALID  in  1  sample present this cycle.
- IN_FIRST  in  1  qualified by IN_VALID; forces this sample to be tap 0 of a new frame.
- PREADD_SUB  in  1  0: PREADD1+PREADD2; 1: PREADD1−PREADD2.
- PREADD1, PREADD2  in  WIDTH_PREADD  pre-adder operands.
- MULTIPLIER  in  WIDTH_MULTIPLIER  coefficient.
- LOAD_DATA  in  WIDTH_PRODUCT  bias; sampled only with tap 0.
- PRODUCT  out  WIDTH_PRODUCT  frame result; holds until next frame completes.
- OUT_VALID  out  1  one-cycle pulse: PRODUCT updated.
- OUT_OVF  out  1  signed overflow occurred during the frame; valid with OUT_VALID.

## Operation
- A sample is accepted at a rising edge with RST_N=1, CE=1 and IN_VALID=1. IN_VALID=0 cycles are gaps and do not advance the frame.
- Tap counter, ceil(log2(NUM_TAPS)) bits, 0..NUM_TAPS-1:
  - Increments per accepted sample and wraps to 0 after NUM_TAPS-1.
  - An accepted sample with IN_FIRST=1 is tap 0 and the counter becomes 1.
  - The partial frame in progress is discarded: no OUT_VALID is produced for it.
  - Tap 0 with IN_FIRST=1 behaves identically to tap 0 without it.
- Stage 1 (preadd):
  - Result is sign-extended to WIDTH_PREADD+1 bits, exact with no wrap.
  - MULTIPLIER, LOAD_DATA and the first/last tags are registered alongside it.
  - last = (tap index == NUM_TAPS-1). For NUM_TAPS=1, every sample is both first and last.
- Stage 2 (multiply): full signed product of WIDTH_PREADD+1+WIDTH_MULTIPLIER bits, sign-extended to WIDTH_PRODUCT.
- Stage 3 (accumulate):
  - The accumulator becomes LOAD_DATA+prod if first, else acc+prod, modulo 2^WIDTH_PRODUCT.
  - Signed overflow occurs when both operands share a sign and the sum sign differs. It sets the frame-overflow bit; a first sample clears the bit and then ORs in its own overflow.
  - If last: PRODUCT ← new accumulator value, OUT_OVF ← frame-overflow including this add, OUT_VALID ← 1. Otherwise OUT_VALID ← 0.
- Pipeline valid bits travel with the data. Stages carrying invalid data do not touch the accumulator.

## Timing
- Reset (async assert, sync-safe release): PRODUCT=0, OUT_VALID=0, OUT_OVF=0. Accumulator, tap counter and pipeline valids also reset to 0.
- Latency: last sample accepted at edge t → PRODUCT/OUT_VALID/OUT_OVF updated at edge t+2 (three register stages).
- Throughput: one sample per enabled cycle, back-to-back frames with no bubble. Tap 0 of frame k+1 may immediately follow the last tap of frame k.
- CE=0: whole pipeline freezes, including OUT_VALID. A pulse stays high until the next enabled edge, and consumers qualify OUT_VALID with CE.
- Reset mid-frame: all in-flight samples and the partial frame are lost. The next accepted sample is tap 0.
- IN_FIRST with the last-tap count pending: the new sample wins and the old frame is discarded.

## Test plan
- NUM_TAPS=4, 4 back-to-back samples: PREADD1=3, PREADD2=2, PREADD_SUB=0, MULTIPLIER=5, LOAD_DATA=100 → single OUT_VALID two edges after the 4th acceptance, PRODUCT=200, OUT_OVF=0.
- Same with PREADD_SUB=1, MULTIPLIER=−7, LOAD_DATA=0, random IN_VALID gaps and CE=0 stalls → PRODUCT=−28, exactly one OUT_VALID.
- Extremes: PREADD1=PREADD2=−2^24, add, MULTIPLIER=−2^17, NUM_TAPS=1 → PRODUCT=2^42, OUT_OVF=0.
- Overflow: NUM_TAPS=1, LOAD_DATA=2^47−1, product 1 → PRODUCT=−2^47, OUT_OVF=1. The next frame without overflow → OUT_OVF=0.
- Realign: NUM_TAPS=4, 2 samples, then IN_FIRST sample plus 3 more (each contributing 1, bias 0) → exactly one OUT_VALID, PRODUCT=4.
- RST_N pulsed low after 2 taps → outputs 0 immediately. The next 4 samples each contributing 10 with bias 0 → PRODUCT=40.
